cpu_io_sequencer: RTL and testbench

Sequences the CPU's output-port run and buffers its results. The block gates the CPU's `startIO` input after a programmable start delay. It captures every `out` word qualified by `outFlag` into an internal FIFO and drains that FIFO to a downstream consumer over a valid/ready handshake. It sits between the CPU top and the result sink (UART/file writer), and replaces the fixed testbench delay before `startIO`.

---
 rtl/cpu_io_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cpu_io_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_sequencer.sv
// Gates CPU startIO after a programmable delay and buffers strobed out words in a 16-deep FWFT FIFO.
// Push lands on dataOut one edge after outFlag; a full FIFO drops the word unless a pop frees a slot that cycle.
module cpu_io_sequencer #(
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 16,
  parameter int PTRWIDTH   = 4,
  parameter int COUNTWIDTH = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  abort,
  input  logic [COUNTWIDTH-1:0] startDelay,
  input  logic [COUNTWIDTH-1:0] totalOutputs,
  input  logic                  outFlag,
  input  logic [WIDTH-1:0]      out,
  output logic                  startIO,
  output logic [WIDTH-1:0]      dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic [COUNTWIDTH-1:0] outCount,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [PTRWIDTH:0] FULL_CNT = (PTRWIDTH + 1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [COUNTWIDTH-1:0]   dly_q, dly_d;
  logic [COUNTWIDTH-1:0]   total_q, total_d;
  logic [COUNTWIDTH-1:0]   out_count_q, out_count_d;
  logic                    overflow_q, overflow_d;
  logic [PTRWIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTRWIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTRWIDTH:0]       fill_q, fill_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];

  logic pop_vld;
  logic push_vld;
  logic drop_vld;
  logic run_start;
  logic last_word;

  // Abort wins over every FIFO and counter update, including a pop in the same cycle.
  always_comb begin
    pop_vld   = (fill_q != '0) && dataReady && !abort;
    push_vld  = (state_q == S_RUN) && outFlag && !abort && ((fill_q != FULL_CNT) || pop_vld);
    drop_vld  = (state_q == S_RUN) && outFlag && !abort && !push_vld;
    run_start = (state_q == S_IDLE) && go && !abort;
    last_word = push_vld && (total_q != '0) &&
                ((out_count_q + COUNTWIDTH'(1)) == total_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (go)             state_d = S_WAIT;
        S_WAIT:  if (dly_q == '0)    state_d = S_RUN;
        S_RUN:   if (last_word)      state_d = S_DRAIN;
        S_DRAIN: if (fill_q == '0)   state_d = S_DONE;
        S_DONE:  if (!go)            state_d = S_IDLE;
        default:                     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    startIO = (state_q == S_RUN);
    busy    = (state_q == S_WAIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done    = (state_q == S_DONE);
  end

  // Run bookkeeping: the delay and word limit are captured once, when the run is launched.
  always_comb begin
    dly_d       = dly_q;
    total_d     = total_q;
    out_count_d = out_count_q;
    overflow_d  = overflow_q;
    if (run_start) begin
      dly_d       = startDelay;
      total_d     = totalOutputs;
      out_count_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if ((state_q == S_WAIT) && !abort && (dly_q != '0)) begin
        dly_d = dly_q - COUNTWIDTH'(1);
      end
      if (push_vld) begin
        out_count_d = out_count_q + COUNTWIDTH'(1);
      end
      if (drop_vld) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push_vld) begin
        wr_ptr_d = wr_ptr_q + PTRWIDTH'(1);
      end
      if (pop_vld) begin
        rd_ptr_d = rd_ptr_q + PTRWIDTH'(1);
      end
      case ({push_vld, pop_vld})
        2'b10:   fill_d = fill_q + (PTRWIDTH + 1)'(1);
        2'b01:   fill_d = fill_q - (PTRWIDTH + 1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dly_q       <= '0;
      total_q     <= '0;
      out_count_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      dly_q       <= dly_d;
      total_q     <= total_d;
      out_count_q <= out_count_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
    end
  end

  // Storage needs no reset: dataOut is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push_vld) begin
      mem_q[wr_ptr_q] <= out;
    end
  end

  always_comb begin
    dataValid = (fill_q != '0);
    dataOut   = dataValid ? mem_q[rd_ptr_q] : '0;
    outCount  = out_count_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_cpu_io_sequencer.sv
// Directed bench for cpu_io_sequencer: one task per scenario, inline checks against hand-derived values.
module tb_cpu_io_sequencer;

  logic        clock;
  logic        reset;
  logic        go;
  logic        abort;
  logic [23:0] startDelay;
  logic [23:0] totalOutputs;
  logic        outFlag;
  logic [23:0] out;
  logic        startIO;
  logic [23:0] dataOut;
  logic        dataValid;
  logic        dataReady;
  logic [23:0] outCount;
  logic        overflow;
  logic        busy;
  logic        done;

  int total;
  int bad;

  cpu_io_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .go           (go),
    .abort        (abort),
    .startDelay   (startDelay),
    .totalOutputs (totalOutputs),
    .outFlag      (outFlag),
    .out          (out),
    .startIO      (startIO),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .dataReady    (dataReady),
    .outCount     (outCount),
    .overflow     (overflow),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch a run with startDelay 0: after this the DUT is in RUN.
  task automatic launch(input logic [23:0] tot);
    startDelay   = 24'd0;
    totalOutputs = tot;
    go           = 1'b1;
    tick();
    go           = 1'b0;
    tick();
  endtask

  task automatic do_abort();
    outFlag = 1'b0;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (startIO !== 1'b0)   begin bad++; $display("FAIL reset_startIO got %0h want 0", startIO); end
    total++; if (dataValid !== 1'b0) begin bad++; $display("FAIL reset_dataValid got %0h want 0", dataValid); end
    total++; if (dataOut !== 24'd0)  begin bad++; $display("FAIL reset_dataOut got %0h want 0", dataOut); end
    total++; if (outCount !== 24'd0) begin bad++; $display("FAIL reset_outCount got %0h want 0", outCount); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got %0h want 0", overflow); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got %0h want 0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got %0h want 0", done); end
  endtask

  task automatic test_delay();
    startDelay   = 24'd5;
    totalOutputs = 24'd0;
    go           = 1'b1;
    tick();
    go = 1'b0;
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL delay_busy_e0 got %0h want 1", busy); end
    total++; if (startIO !== 1'b0) begin bad++; $display("FAIL delay_startIO_e0 got %0h want 0", startIO); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++; if (startIO !== 1'b0) begin bad++; $display("FAIL delay_startIO_e%0d got %0h want 0", i, startIO); end
    end
    tick();
    total++; if (startIO !== 1'b1) begin bad++; $display("FAIL delay_startIO_e6 got %0h want 1", startIO); end
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL delay_busy_e6 got %0h want 1", busy); end
    do_abort();
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL delay_abort_busy got %0h want 0", busy); end
  endtask

  task automatic test_bounded();
    dataReady = 1'b1;
    startDelay   = 24'd0;
    totalOutputs = 24'd4;
    go = 1'b1;
    tick();
    tick();
    total++; if (startIO !== 1'b1) begin bad++; $display("FAIL bnd_startIO_run got %0h want 1", startIO); end
    for (int i = 1; i <= 4; i++) begin
      out     = 24'(i);
      outFlag = 1'b1;
      tick();
      total++; if (dataValid !== 1'b1)   begin bad++; $display("FAIL bnd_valid_%0d got %0h want 1", i, dataValid); end
      total++; if (dataOut !== 24'(i))   begin bad++; $display("FAIL bnd_data_%0d got %0h want %0h", i, dataOut, i); end
      total++; if (outCount !== 24'(i))  begin bad++; $display("FAIL bnd_count_%0d got %0h want %0h", i, outCount, i); end
    end
    outFlag = 1'b0;
    total++; if (startIO !== 1'b0) begin bad++; $display("FAIL bnd_startIO_fall got %0h want 0", startIO); end
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL bnd_busy_drain got %0h want 1", busy); end
    tick();
    total++; if (dataValid !== 1'b0) begin bad++; $display("FAIL bnd_valid_empty got %0h want 0", dataValid); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL bnd_done_early got %0h want 0", done); end
    tick();
    total++; if (done !== 1'b1)        begin bad++; $display("FAIL bnd_done got %0h want 1", done); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL bnd_busy_done got %0h want 0", busy); end
    total++; if (outCount !== 24'd4)   begin bad++; $display("FAIL bnd_outCount got %0h want 4", outCount); end
    tick();
    total++; if (done !== 1'b1)    begin bad++; $display("FAIL bnd_done_hold got %0h want 1", done); end
    total++; if (startIO !== 1'b0) begin bad++; $display("FAIL bnd_no_restart got %0h want 0", startIO); end
    go = 1'b0;
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL bnd_idle_done got %0h want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bnd_idle_busy got %0h want 0", busy); end
  endtask

  task automatic test_full_push_pop();
    dataReady = 1'b0;
    launch(24'd0);
    for (int i = 0; i < 16; i++) begin
      out     = 24'h000200 + 24'(i);
      outFlag = 1'b1;
      tick();
    end
    total++; if (outCount !== 24'd16) begin bad++; $display("FAIL full_count got %0h want 10", outCount); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL full_ovf got %0h want 0", overflow); end
    out       = 24'h0002AA;
    dataReady = 1'b1;
    tick();
    total++; if (overflow !== 1'b0)      begin bad++; $display("FAIL pp_ovf got %0h want 0", overflow); end
    total++; if (outCount !== 24'd17)    begin bad++; $display("FAIL pp_count got %0h want 11", outCount); end
    total++; if (dataOut !== 24'h000201) begin bad++; $display("FAIL pp_head got %0h want 201", dataOut); end
    out       = 24'h0002BB;
    dataReady = 1'b0;
    tick();
    total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL pp_still_full_ovf got %0h want 1", overflow); end
    total++; if (outCount !== 24'd17) begin bad++; $display("FAIL pp_drop_count got %0h want 11", outCount); end
    do_abort();
  endtask

  task automatic test_overflow();
    dataReady = 1'b0;
    launch(24'd0);
    for (int i = 0; i < 17; i++) begin
      out     = 24'h000100 + 24'(i);
      outFlag = 1'b1;
      tick();
    end
    outFlag = 1'b0;
    total++; if (outCount !== 24'd16) begin bad++; $display("FAIL ovf_count got %0h want 10", outCount); end
    total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_flag got %0h want 1", overflow); end
    total++; if (startIO !== 1'b1)    begin bad++; $display("FAIL ovf_unbounded_run got %0h want 1", startIO); end
    dataReady = 1'b1;
    for (int j = 0; j < 16; j++) begin
      total++; if (dataValid !== 1'b1) begin bad++; $display("FAIL ovf_drain_valid_%0d got %0h want 1", j, dataValid); end
      total++; if (dataOut !== 24'h000100 + 24'(j)) begin bad++; $display("FAIL ovf_drain_data_%0d got %0h want %0h", j, dataOut, 24'h000100 + 24'(j)); end
      tick();
    end
    total++; if (dataValid !== 1'b0) begin bad++; $display("FAIL ovf_17th_present got %0h want 0", dataValid); end
    tick();
    total++; if (dataValid !== 1'b0) begin bad++; $display("FAIL ovf_17th_late got %0h want 0", dataValid); end
    do_abort();
    total++; if (outCount !== 24'd16) begin bad++; $display("FAIL ovf_abort_count got %0h want 10", outCount); end
    total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_abort_flag got %0h want 1", overflow); end
  endtask

  task automatic test_abort();
    dataReady = 1'b0;
    launch(24'd0);
    for (int i = 0; i < 5; i++) begin
      out     = 24'h000300 + 24'(i);
      outFlag = 1'b1;
      tick();
    end
    outFlag = 1'b0;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy got %0h want 0", busy); end
    total++; if (dataValid !== 1'b0) begin bad++; $display("FAIL abort_valid got %0h want 0", dataValid); end
    total++; if (startIO !== 1'b0)   begin bad++; $display("FAIL abort_startIO got %0h want 0", startIO); end
    total++; if (outCount !== 24'd5) begin bad++; $display("FAIL abort_count got %0h want 5", outCount); end
    dataReady = 1'b1;
    tick();
    total++; if (dataValid !== 1'b0) begin bad++; $display("FAIL abort_flushed got %0h want 0", dataValid); end
  endtask

  task automatic test_reset_midrun();
    dataReady = 1'b0;
    launch(24'd0);
    for (int i = 0; i < 3; i++) begin
      out     = 24'h000400 + 24'(i);
      outFlag = 1'b1;
      tick();
    end
    outFlag = 1'b0;
    total++; if (dataValid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got %0h want 1", dataValid); end
    reset = 1'b0;
    #1;
    total++; if (startIO !== 1'b0)   begin bad++; $display("FAIL rst_async_startIO got %0h want 0", startIO); end
    total++; if (dataValid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got %0h want 0", dataValid); end
    total++; if (outCount !== 24'd0) begin bad++; $display("FAIL rst_async_count got %0h want 0", outCount); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_async_busy got %0h want 0", busy); end
    #1;
    reset        = 1'b1;
    startDelay   = 24'd0;
    totalOutputs = 24'd0;
    go           = 1'b1;
    tick();
    total++; if (startIO !== 1'b0) begin bad++; $display("FAIL rst_restart_e0 got %0h want 0", startIO); end
    tick();
    total++; if (startIO !== 1'b1) begin bad++; $display("FAIL rst_restart_e1 got %0h want 1", startIO); end
    go = 1'b0;
    do_abort();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    go           = 1'b0;
    abort        = 1'b0;
    startDelay   = 24'd0;
    totalOutputs = 24'd0;
    outFlag      = 1'b0;
    out          = 24'd0;
    dataReady    = 1'b0;
    #3;
    test_reset();
    reset = 1'b1;
    tick();
    test_delay();
    test_bounded();
    test_full_push_pop();
    test_overflow();
    test_abort();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
